// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port data memory arbiter with bounded bursts and registered read data.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic [4:0]        memi0_i,
    input  logic [4:0]        memi1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic [4:0]        mem_memi_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rd_i
);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e              state_q, state_d;
    logic                lsp_q, lsp_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                own0, own1, xfer, burst_done;

    always_comb begin
        own0       = state_q == OWN0;
        own1       = state_q == OWN1;
        gnt0_o     = own0 & req0_i;
        gnt1_o     = own1 & req1_i;
        mem_addr_o = own0 ? addr0_i : own1 ? addr1_i : '0;
        mem_wd_o   = own0 ? wd0_i : own1 ? wd1_i : '0;
        mem_memi_o = own0 ? memi0_i : own1 ? memi1_i : '0;
        mem_we_o   = (gnt0_o & we0_i) | (gnt1_o & we1_i);
        xfer       = gnt0_o | gnt1_o;
        cnt_inc    = (xfer && cnt_q != CW'(BURST_LEN)) ? cnt_q + 1'b1 : cnt_q;
        burst_done = cnt_inc == CW'(BURST_LEN);
        lsp_d      = xfer ? own1 : lsp_q;
        rvalid0_d  = gnt0_o & ~we0_i;
        rvalid1_d  = gnt1_o & ~we1_i;
        rdata_d    = (xfer && !mem_we_o) ? mem_rd_i : rdata_q;
        state_d    = state_q;
        cnt_d      = cnt_inc;
        // lsp_q == 1 means port 1 was served last, so a tie goes to port 0
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = (req0_i && req1_i) ? (lsp_q ? OWN0 : OWN1) :
                          req0_i ? OWN0 : req1_i ? OWN1 : IDLE;
            end
            OWN0: begin
                if (!req0_i) begin
                    state_d = req1_i ? OWN1 : IDLE;
                    cnt_d   = '0;
                end else if (burst_done && req1_i) begin
                    state_d = OWN1;
                    cnt_d   = '0;
                end
            end
            OWN1: begin
                if (!req1_i) begin
                    state_d = req0_i ? OWN0 : IDLE;
                    cnt_d   = '0;
                end else if (burst_done && req0_i) begin
                    state_d = OWN0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            lsp_q     <= 1'b1;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lsp_q     <= lsp_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against an ownership/queue-level reference model.
module tb_dmem_arbiter;
    localparam int BL = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [4:0]  memi0 = '0, memi1 = '0;
    logic        gnt0, gnt1, rv0, rv1, mwe;
    logic [31:0] rdata, maddr, mwd, mrd;
    logic [4:0]  mmemi;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wd0_i(wd0), .wd1_i(wd1),
        .memi0_i(memi0), .memi1_i(memi1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rv0), .rvalid1_o(rv1),
        .rdata_o(rdata), .mem_addr_o(maddr), .mem_wd_o(mwd), .mem_memi_o(mmemi),
        .mem_we_o(mwe), .mem_rd_i(mrd)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01010101) ^ 32'hA5A50000);
    endfunction

    // data memory seen by the DUT: combinational read, write on the clock edge
    logic [31:0] dmem [256];
    bit          inited = 1'b0;
    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
            inited <= 1'b1;
        end else if (mwe) dmem[maddr[9:2]] <= mwd;
    end
    assign mrd = dmem[maddr[9:2]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: owner (-1 none), transfers in current tenure, last served port
    int          owner = -1, run = 0, last = 1;
    logic        e_rv0 = 1'b0, e_rv1 = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [31:0] ref_mem [256];
    bit          ref_init = 1'b0;

    always @(negedge clk) begin : model
        logic        eg0, eg1, ewe, rq_own, rq_oth;
        logic [31:0] ea, ewd;
        logic [4:0]  em;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0); chk("rst_we", mwe, 0);
            chk("rst_addr", maddr, 0); chk("rst_wd", mwd, 0); chk("rst_memi", mmemi, 0);
            chk("rst_rv0", rv0, 0); chk("rst_rv1", rv1, 0); chk("rst_rdata", rdata, 0);
            owner = -1; run = 0; last = 1; e_rv0 = 1'b0; e_rv1 = 1'b0; e_rdata = '0;
        end else begin
            eg0 = owner == 0 && req0;
            eg1 = owner == 1 && req1;
            ea  = owner == 0 ? addr0 : owner == 1 ? addr1 : 32'h0;
            ewd = owner == 0 ? wd0 : owner == 1 ? wd1 : 32'h0;
            em  = owner == 0 ? memi0 : owner == 1 ? memi1 : 5'h0;
            ewe = (eg0 && we0) || (eg1 && we1);
            chk("gnt0", gnt0, eg0); chk("gnt1", gnt1, eg1); chk("mem_we", mwe, ewe);
            chk("mem_addr", maddr, ea); chk("mem_wd", mwd, ewd); chk("mem_memi", mmemi, em);
            chk("rvalid0", rv0, e_rv0); chk("rvalid1", rv1, e_rv1); chk("rdata", rdata, e_rdata);
            e_rv0 = 1'b0;
            e_rv1 = 1'b0;
            if (eg0 || eg1) begin
                run  = run < BL ? run + 1 : BL;
                last = owner;
                if (ewe) ref_mem[ea[9:2]] = ewd;
                else begin
                    e_rdata = ref_mem[ea[9:2]];
                    if (owner == 0) e_rv0 = 1'b1; else e_rv1 = 1'b1;
                end
            end
            if (owner < 0) begin
                owner = (req0 && req1) ? 1 - last : req0 ? 0 : req1 ? 1 : -1;
                run   = 0;
            end else begin
                rq_own = owner == 0 ? req0 : req1;
                rq_oth = owner == 0 ? req1 : req0;
                if (!rq_own) begin
                    owner = rq_oth ? 1 - owner : -1;
                    run   = 0;
                end else if (run == BL && rq_oth) begin
                    owner = 1 - owner;
                    run   = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] g0s, g1s;
        int          n;
        bit          seen, g0_last, g1_last;
        repeat (3) step();
        rst_n = 1'b1;
        samp();
        chk("rel_gnt0", gnt0, 0); chk("rel_rdata", rdata, 0); chk("rel_addr", maddr, 0);
        // single read of 0x10
        step(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; memi0 = 5'h0A;
        step(); samp();
        chk("rd_gnt0", gnt0, 1); chk("rd_addr", maddr, 32'h10); chk("rd_memi", mmemi, 5'h0A);
        step(); req0 = 1'b0; samp();
        chk("rd_rv0", rv0, 1); chk("rd_data", rdata, 32'hDEADBEEF); chk("rd_rv1", rv1, 0);
        step(); samp();
        chk("rd_rv0_off", rv0, 0); chk("rd_hold", rdata, 32'hDEADBEEF);
        // reset in the middle of a write grant
        step(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wd0 = 32'h77;
        step();
        chk("mw_gnt0", gnt0, 1); chk("mw_we", mwe, 1);
        rst_n = 1'b0;
        #1;
        chk("mw_gnt0_drop", gnt0, 0); chk("mw_we_drop", mwe, 0);
        req0 = 1'b0; we0 = 1'b0;
        step(); step(); rst_n = 1'b1;
        samp();
        chk("mw_rdata_clr", rdata, 0); chk("mw_addr", maddr, 0); chk("mw_rv0", rv0, 0);
        // tie after reset, then alternating bursts of BL
        step(); req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h14;
        for (int i = 0; i < 12; i++) begin
            step(); samp();
            g0s[i] = gnt0;
            g1s[i] = gnt1;
        end
        chk("burst_g0", g0s, 12'b1111_0000_1111);
        chk("burst_g1", g1s, 12'b0000_1111_0000);
        step(); req0 = 1'b0; req1 = 1'b0;
        // port 1 alone: ten back-to-back writes
        step(); req1 = 1'b1; we1 = 1'b1; memi1 = 5'h12; addr1 = 32'h100; wd1 = 32'h1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            addr1 = 32'h100 + 32'(i) * 4;
            wd1   = 32'(i + 1);
            samp();
            if (gnt1) n++;
            chk("nc_memi", mmemi, 5'h12);
        end
        chk("nc_grants", n, 10);
        step(); req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 9) addr0 = 32'h104 + 32'(i) * 4; else req0 = 1'b0;
            samp();
            chk("rb_rv0", rv0, 1);
            chk("rb_data", rdata, 32'(i + 1));
        end
        // port 0 writes 0x55 to 0x20, port 1 reads it after the handover
        step(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wd0 = 32'h55;
        step(); req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        samp();
        chk("mx_gnt0", gnt0, 1); chk("mx_we", mwe, 1);
        step(); req0 = 1'b0; we0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            samp();
            if (gnt1) seen = 1'b1; else step();
        end
        chk("mx_gnt1_seen", seen, 1);
        step(); req1 = 1'b0;
        samp();
        chk("mx_rv1", rv1, 1); chk("mx_rv0", rv0, 0); chk("mx_data", rdata, 32'h55);
        // randomized traffic with one asynchronous reset
        g0_last = 1'b0;
        g1_last = 1'b0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (c == 302) rst_n = 1'b1;
            if (!req0 || g0_last) begin
                req0  = $urandom_range(0, 3) != 0;
                we0   = 1'($urandom_range(0, 1));
                addr0 = 32'h200 + 32'($urandom_range(0, 15)) * 4;
                wd0   = $urandom;
                memi0 = 5'($urandom_range(0, 31));
            end
            if (!req1 || g1_last) begin
                req1  = $urandom_range(0, 3) != 0;
                we1   = 1'($urandom_range(0, 1));
                addr1 = 32'h200 + 32'($urandom_range(0, 15)) * 4;
                wd1   = $urandom;
                memi1 = 5'($urandom_range(0, 31));
            end
            if (c == 300) begin
                #2;
                rst_n = 1'b0;
            end
            samp();
            g0_last = gnt0;
            g1_last = gnt1;
        end
        step(); req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory between the core's load/store port (port 0) and a secondary master (port 1, e.g. a program loader or debug port). It multiplexes address, write data, access size code (memi) and write enable onto the memory, grants access round-robin with a bounded burst length, and returns registered read data with a valid strobe. It sits between the core's memory interface and the data memory in the processor top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BURST_LEN, 4, max consecutive granted transfers per owner while the other port is requesting (≥1)

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low
- req0_i / req1_i  in  1  transfer request; held until granted
- we0_i / we1_i  in  1  1 = write, 0 = read
- addr0_i / addr1_i  in  ADDR_W  byte address
- wd0_i / wd1_i  in  DATA_W  write data
- memi0_i / memi1_i  in  5  access size/sign code, passed through unchanged
- gnt0_o / gnt1_o  out  1  transfer accepted this cycle
- rvalid0_o / rvalid1_o  out  1  read data valid (one cycle)
- rdata_o  out  DATA_W  registered read data, shared by both ports
- mem_addr_o  out  ADDR_W  to data memory
- mem_wd_o  out  DATA_W  to data memory
- mem_memi_o  out  5  to data memory
- mem_we_o  out  1  to data memory
- mem_rd_i  in  DATA_W  combinational read data from data memory

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last-served port (lsp), burst counter cnt, rdata, rvalid0/1.
- IDLE: memory outputs all zero, no grants. Next state: one port requesting → OWN of that port; both → OWN of the port ≠ lsp; neither → IDLE.
- OWNn: memory outputs = port n's addr/wd/memi; gnt_n_o = req_n_i (combinational); mem_we_o = req_n_i & we_n_i. Other port's gnt is 0.
- A transfer happens in any cycle with req_n & gnt_n. On each transfer: cnt increments (saturating at BURST_LEN); lsp ← n.
- Read transfer (we = 0): rdata ← mem_rd_i, rvalid_n ← 1 at the edge; otherwise rvalid_n ← 0.
- OWNn exit (evaluated each edge):
  - req_n low → OWNm if other port m requesting, else IDLE; cnt ← 0.
  - cnt reaches BURST_LEN with this edge's transfer and req_m high → OWNm, cnt ← 0.
  - Otherwise stay; port n keeps ownership indefinitely while m is idle (cnt saturates, no wrap).
- Handover OWN0↔OWN1 is direct, no dead cycle.
- memi and address alignment are not checked; passed through unchanged.

## Timing
- Reset (rst_i low, any time, async): state = IDLE, lsp = port 1 (port 0 wins the first tie), cnt = 0, rdata_o = 0, rvalid0_o = rvalid1_o = 0; gnt*, mem_we_o, mem_addr_o, mem_wd_o, mem_memi_o = 0 immediately. An in-flight write is aborted (mem_we_o falls in the reset cycle); no write occurs on the edge during reset.
- Arbitration latency from IDLE: request in cycle t → grant in cycle t+1. Back-to-back transfers with the same owner: 1 per cycle.
- Read latency: data on rdata_o with rvalid high in the cycle after the grant cycle.
- Write: committed by the data memory on the edge ending the grant cycle.
- Req dropped in the same cycle the other port raises req: that port is granted the next cycle.
- rdata_o holds its last value when rvalid is low.

## Test plan
- Reset: assert rst_i mid-write in OWN0 → mem_we_o and gnt0_o drop in the same cycle; after release all outputs are 0; state IDLE.
- Single read: port 0 reads addr 0x10 (memory holds 0xDEADBEEF) → gnt0_o high at t+1, rdata_o = 0xDEADBEEF and rvalid0_o = 1 at t+2, for one cycle.
- Tie after reset: both request at the same cycle → port 0 granted first; port 1 granted after port 0 drops req or after 4 transfers.
- Burst limit: port 0 requests continuously, port 1 requests from cycle 2 → port 0 gets exactly 4 grants, then port 1 granted in the next cycle with no gap; port 1 holding 4 more → back to port 0.
- No contention: port 1 alone issues 10 back-to-back writes of 0x1..0xA to 0x100..0x124 → 10 consecutive grants, memory readback by port 0 matches, memi passed unchanged.
- Mixed: port 0 write 0x55 to 0x20, port 1 read 0x20 immediately after the handover → port 1 reads 0x55; rvalid1_o only, rvalid0_o stays 0.
